shift_cmd_seq: RTL

- Command sequencer that sits directly upstream of the combinational 16-bit shifter `shfter` (ports src, amt, rotate, res) and instantiates it.
- Buffers shift commands in a small FIFO, presents one command at a time to the shifter, and registers the result.
- Returns results in order on a valid/ready output handshake, giving the datapath a registered, back-pressurable shift service.

---
 rtl/shift_cmd_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/shift_cmd_seq.sv
// Shift command sequencer: FIFO-buffered commands feed the combinational shfter; results are registered and returned in order on a valid/ready handshake.
// Optional `define SHIFT_CNT_EN adds done_cnt, a saturating count of completed result handshakes.
`timescale 1ns/1ps

module shfter (
  input  logic [15:0] src,
  input  logic [3:0]  amt,
  input  logic        rotate,
  output logic [15:0] res
);
  logic [31:0] w_dbl;

  // Upper half of the doubled operand shifted left is the left rotation.
  assign w_dbl = {src, src} << amt;
  assign res   = rotate ? w_dbl[31:16] : (src << amt);
endmodule

module shift_cmd_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [15:0] cmd_src,
  input  logic [3:0]  cmd_amt,
  input  logic        cmd_rot,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic [15:0] res_out,
  output logic        busy
`ifdef SHIFT_CNT_EN
  ,
  output logic [7:0]  done_cnt
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t      r_state, w_next;
  logic [20:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic [15:0] r_src_q;
  logic [3:0]  r_amt_q;
  logic        r_rot_q;
  logic [15:0] r_res;
  logic        w_push, w_pop, w_capture, w_hs, w_nonempty;
  logic [15:0] w_shift;

  shfter u_shfter (
    .src    (r_src_q),
    .amt    (r_amt_q),
    .rotate (r_rot_q),
    .res    (w_shift)
  );

  assign w_nonempty = (r_count != '0);
  assign cmd_rdy    = (r_count != FULL_CNT);
  assign w_push     = cmd_vld && cmd_rdy && !flush;
  assign w_hs       = (r_state == HOLD) && res_rdy && !flush;
  assign res_vld    = (r_state == HOLD);
  assign res_out    = r_res;
  assign busy       = (r_state != IDLE) || w_nonempty;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: if (w_nonempty) begin
        w_pop  = 1'b1;
        w_next = EXEC;
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = HOLD;
      end
      HOLD: if (res_rdy) begin
        if (w_nonempty) begin
          w_pop  = 1'b1;
          w_next = EXEC;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // flush overrides every transition, pop and capture in the same cycle.
    if (flush) begin
      w_next    = IDLE;
      w_pop     = 1'b0;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_src, cmd_amt, cmd_rot};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_src_q  <= '0;
      r_amt_q  <= '0;
      r_rot_q  <= 1'b0;
      r_res    <= '0;
    end else begin
      r_state <= w_next;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (w_pop) {r_src_q, r_amt_q, r_rot_q} <= r_mem[r_rd_ptr];
      if (w_capture) r_res <= w_shift;
    end
  end

`ifdef SHIFT_CNT_EN
  logic [7:0] r_done_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (flush) begin
      r_done_cnt <= '0;
    end else if (w_hs && (r_done_cnt != '1)) begin
      r_done_cnt <= r_done_cnt + 1'b1;
    end
  end

  assign done_cnt = r_done_cnt;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_hs;
`endif
endmodule
